// File: rtl/pipe_stall_seq.sv
// Pipeline stall/flush/halt sequencer: controls are combinational from state + hazard inputs, zero latency.
// No backpressure; stall dominates flush and halt, and HOLD defers halt until it completes.
module pipe_stall_seq #(
    parameter int HOLD_EXTRA = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             stall2,
    input  logic             c_adventure,
    input  logic             halt_req,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] HCNT_INIT = 2'(HOLD_EXTRA - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_hcnt;
    logic [1:0]       w_hcnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_hcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        case (r_state)
            ST_RUN: begin
                if (stall) begin
                    if (stall2) begin
                        w_state_nxt = ST_HOLD;
                        w_hcnt_nxt  = HCNT_INIT;
                    end
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HOLD: begin
                if (r_hcnt == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hcnt_nxt = r_hcnt - 2'd1;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_hcnt_nxt  = 2'd0;
            end
        endcase
    end

    // Halt also suppresses a same-cycle flush: the branch is re-evaluated once fetch resumes.
    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (stall || halt_req) begin
                    PC_en       = 1'b0;
                    IFID_en     = 1'b0;
                    IDEX_bubble = 1'b1;
                end else if (c_adventure) begin
                    IFID_flush = 1'b1;
                end
            end
            default: begin
                PC_en       = 1'b0;
                IFID_en     = 1'b0;
                IDEX_bubble = 1'b1;
            end
        endcase
    end

    assign busy = (r_state == ST_HOLD) || (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!PC_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (IFID_flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_stall_seq.sv
// Randomized + directed bench for pipe_stall_seq; a cycle-level reference model feeds a scoreboard queue.
module tb_pipe_stall_seq;

    localparam int HOLD_EXTRA = 1;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, stall2, c_adventure, halt_req;
    logic             PC_en, IFID_en, IFID_flush, IDEX_bubble, busy;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipe_stall_seq #(.HOLD_EXTRA(HOLD_EXTRA), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall(stall), .stall2(stall2), .c_adventure(c_adventure), .halt_req(halt_req),
        .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
        .busy(busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc, ifid, ifid_dc, fl, bub, bsy;
        int   sc, fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: frozen cycles still owed to a load-then-branch, and whether fetch is halted.
    int   m_frozen_left = 0;
    bit   m_halted      = 0;
    int   m_sc          = 0;
    int   m_fc          = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_frozen_left = 0;
        m_halted      = 0;
        m_sc          = 0;
        m_fc          = 0;
    endtask

    task automatic step(input logic s, input logic s2, input logic ca, input logic h);
        exp_t e;
        @(posedge clk);
        #1;
        stall = s; stall2 = s2; c_adventure = ca; halt_req = h;
        e.bsy = (m_frozen_left > 0) || m_halted;
        e.sc = m_sc; e.fc = m_fc;
        e.pc = 1'b1; e.ifid = 1'b1; e.ifid_dc = 1'b0; e.fl = 1'b0; e.bub = 1'b0;
        if (m_frozen_left > 0) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
            m_frozen_left--;
        end else if (m_halted) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
            if (!h) m_halted = 0;
        end else if (s) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
            if (s2) m_frozen_left = HOLD_EXTRA;
        end else if (h) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
            m_halted = 1;
        end else if (ca) begin
            e.fl = 1'b1; e.ifid_dc = 1'b1;
        end
        q.push_back(e);
        if (!e.pc) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
        if (e.fl)  m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
    endtask

    // Monitor: outputs are meaningful every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("PC_en", int'(PC_en), int'(e.pc));
                if (!e.ifid_dc) check("IFID_en", int'(IFID_en), int'(e.ifid));
                check("IFID_flush", int'(IFID_flush), int'(e.fl));
                check("IDEX_bubble", int'(IDEX_bubble), int'(e.bub));
                check("busy", int'(busy), int'(e.bsy));
                check("stall_cycles", int'(stall_cycles), e.sc);
                check("flush_count", int'(flush_count), e.fc);
            end
        end
    end

    initial begin
        int halt_left;
        logic s, s2, ca, h;
        rst_n = 1'b0; stall = 1'b0; stall2 = 1'b0; c_adventure = 1'b0; halt_req = 1'b0;
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_stall_cycles", int'(stall_cycles), 0);
        check("reset_flush_count", int'(flush_count), 0);
        check("reset_PC_en", int'(PC_en), 1);
        #5 rst_n = 1'b1;

        // Single stall
        step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        // Load-then-branch, with stall2 repeated during HOLD
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        // Stall colliding with a taken branch, then the branch alone
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
        // Halt for five cycles
        repeat (5) step(0, 0, 0, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        // Halt requested during HOLD and alongside a stall
        step(1, 1, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        // Counter saturation
        repeat (20) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(1, 0, 0, 0);

        // Asynchronous reset in the middle of HOLD
        step(1, 1, 0, 0);
        @(posedge clk);
        #1;
        stall = 1'b0; stall2 = 1'b0; c_adventure = 1'b0; halt_req = 1'b0;
        check("busy_mid_hold", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_stall_cycles", int'(stall_cycles), 0);
        check("async_rst_flush_count", int'(flush_count), 0);
        check("async_rst_PC_en", int'(PC_en), 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0); step(0, 0, 1, 0);

        // Randomized traffic
        halt_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (halt_left > 0) begin
                h = 1'b1; halt_left--;
            end else if ($urandom % 25 == 0) begin
                h = 1'b1; halt_left = $urandom_range(0, 4);
            end else begin
                h = 1'b0;
            end
            s  = ($urandom % 4 == 0);
            s2 = s && ($urandom % 2 == 0);
            ca = h ? 1'b0 : ($urandom % 4 == 0);
            step(s, s2, ca, h);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
